// File: rtl/hazard_pkg.sv
// Shared types and constants for the E-stage hazard/forwarding unit.
// Forward select codes, hazard FSM states and the x0 register constant.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LDSTALL = 2'b01,
        MCWAIT  = 2'b10
    } hz_state_e;

    localparam int unsigned REG_ZERO = 0;

    // Width of the load-use stall down-counter (covers LOAD_STALL_CYC up to 3).
    localparam int unsigned LDCNT_W = 2;

    // M-stage hit outranks W-stage hit, so the code 2'b11 is never produced.
    function automatic fwd_sel_e pick_source(input logic hit_m, input logic hit_w);
        fwd_sel_e sel;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forward_mux3.sv
// Combinational 3:1 operand mux for E-stage forwarding.
// Selects register-file, W-stage or M-stage value by forward code.
module forward_mux3
    import hazard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  fwd_sel_e        sel,
    input  logic [XLEN-1:0] rf_val,
    input  logic [XLEN-1:0] w_val,
    input  logic [XLEN-1:0] m_val,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = rf_val;
        case (sel)
            FWD_W:   y = w_val;
            FWD_M:   y = m_val;
            default: y = rf_val;
        endcase
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// E-stage forwarding, load-use stall, branch flush and multi-cycle-op stall.
// Optional saturating stall counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              MultiStartE,
    input  logic              MultiDoneE,
    input  logic [XLEN-1:0]   RD1E,
    input  logic [XLEN-1:0]   RD2E,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   ResultW,
    output logic [XLEN-1:0]   SrcAE,
    output logic [XLEN-1:0]   SrcBE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCount
`endif
);

    localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_ZERO);

    hz_state_e           state;
    hz_state_e           state_next;
    logic [LDCNT_W-1:0]  cnt;
    logic [LDCNT_W-1:0]  cnt_next;
    logic [XLEN-1:0]     hold_a;
    logic [XLEN-1:0]     hold_b;
    logic                capture;

    logic                hit_m_a;
    logic                hit_w_a;
    logic                hit_m_b;
    logic                hit_w_b;
    fwd_sel_e            fwd_a;
    fwd_sel_e            fwd_b;
    logic [XLEN-1:0]     mux_a;
    logic [XLEN-1:0]     mux_b;
    logic                load_use;

    logic                stall_f;
    logic                stall_d;
    logic                stall_e;
    logic                flush_d;
    logic                flush_e;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign hit_m_a = RegWriteM && (RdM != X0) && (RdM == Rs1E);
    assign hit_w_a = RegWriteW && (RdW != X0) && (RdW == Rs1E);
    assign hit_m_b = RegWriteM && (RdM != X0) && (RdM == Rs2E);
    assign hit_w_b = RegWriteW && (RdW != X0) && (RdW == Rs2E);

    assign fwd_a = pick_source(hit_m_a, hit_w_a);
    assign fwd_b = pick_source(hit_m_b, hit_w_b);

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    forward_mux3 #(.XLEN(XLEN)) u_mux_a (
        .sel    (fwd_a),
        .rf_val (RD1E),
        .w_val  (ResultW),
        .m_val  (ALUResultM),
        .y      (mux_a)
    );

    forward_mux3 #(.XLEN(XLEN)) u_mux_b (
        .sel    (fwd_b),
        .rf_val (RD2E),
        .w_val  (ResultW),
        .m_val  (ALUResultM),
        .y      (mux_b)
    );

    // M/W sources retire while E waits, so the operands captured at issue are replayed.
    assign SrcAE = (state == MCWAIT) ? hold_a : mux_a;
    assign SrcBE = (state == MCWAIT) ? hold_b : mux_b;

    assign load_use = LoadE && (RdE != X0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                hold_a <= mux_a;
                hold_b <= mux_b;
            end
        end
    end

    // A taken branch outranks a load-use hazard: the hazard's consumer is being flushed anyway.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (PCSrcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            state_next = LDSTALL;
                            cnt_next   = LDCNT_W'(LOAD_STALL_CYC - 1);
                        end
                    end else if (MultiStartE && !MultiDoneE) begin
                        state_next = MCWAIT;
                        capture    = 1'b1;
                    end
                end
                LDSTALL: begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    flush_e  = 1'b1;
                    cnt_next = cnt - LDCNT_W'(1);
                    if (cnt == LDCNT_W'(1)) begin
                        state_next = IDLE;
                    end
                end
                MCWAIT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    if (MultiDoneE) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign StallF = stall_f;
    assign StallD = stall_d;
    assign StallE = stall_e;
    assign FlushD = flush_d;
    assign FlushE = flush_e;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_f && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign StallCount = stall_count;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus random
// traffic, all compared against a cycle-level reference model.
module tb_hazard_forward_unit;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int LSC   = 2;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [RAW-1:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic            RegWriteM, RegWriteW, LoadE, PCSrcE, MultiStartE, MultiDoneE;
    logic [XLEN-1:0] RD1E, RD2E, ALUResultM, ResultW;
    logic [XLEN-1:0] SrcAE, SrcBE;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            StallF, StallD, StallE, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] StallCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: busy flag, remaining extra load-stall cycles, held operands.
    bit              m_busy;
    int              m_ldrem;
    logic [XLEN-1:0] m_hold_a, m_hold_b;
    int              m_cnt;
    bit              n_busy;
    int              n_ldrem;
    logic [XLEN-1:0] n_hold_a, n_hold_b;
    bit              o_sf;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .XLEN(XLEN), .REG_AW(RAW), .LOAD_STALL_CYC(LSC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MultiStartE(MultiStartE), .MultiDoneE(MultiDoneE),
        .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM), .ResultW(ResultW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCount(StallCount)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [RAW-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] fval(input logic [1:0] code, input logic [XLEN-1:0] rf);
        if (code == 2'b10) return ALUResultM;
        if (code == 2'b01) return ResultW;
        return rf;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, LoadE, PCSrcE, MultiStartE, MultiDoneE} = '0;
        RD1E = '0; RD2E = '0; ALUResultM = '0; ResultW = '0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic eval();
        logic [1:0]      fa, fb;
        logic [XLEN-1:0] la, lb, ea, eb;
        bit sf, sd, se, fd, fe, lu;
        #1;
        if (rst) begin
            m_busy = 0; m_ldrem = 0; m_hold_a = '0; m_hold_b = '0; m_cnt = 0;
        end
        fa = fsel(Rs1E);
        fb = fsel(Rs2E);
        la = fval(fa, RD1E);
        lb = fval(fb, RD2E);
        ea = m_busy ? m_hold_a : la;
        eb = m_busy ? m_hold_b : lb;
        lu = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        {sf, sd, se, fd, fe} = '0;
        n_busy = m_busy; n_ldrem = m_ldrem; n_hold_a = m_hold_a; n_hold_b = m_hold_b;
        if (rst) begin
            n_busy = 0; n_ldrem = 0; n_hold_a = '0; n_hold_b = '0;
        end else if (m_busy) begin
            sf = 1; sd = 1; se = 1;
            if (MultiDoneE) n_busy = 0;
        end else if (m_ldrem > 0) begin
            sf = 1; sd = 1; fe = 1;
            n_ldrem = m_ldrem - 1;
        end else if (PCSrcE) begin
            fd = 1; fe = 1;
        end else if (lu) begin
            sf = 1; sd = 1; fe = 1;
            n_ldrem = LSC - 1;
        end else if (MultiStartE && !MultiDoneE) begin
            n_busy = 1; n_hold_a = la; n_hold_b = lb;
        end
        o_sf = sf;
        chk("ForwardAE", ForwardAE, fa);
        chk("ForwardBE", ForwardBE, fb);
        chk("SrcAE", SrcAE, ea);
        chk("SrcBE", SrcBE, eb);
        chk("StallF", StallF, sf);
        chk("StallD", StallD, sd);
        chk("StallE", StallE, se);
        chk("FlushD", FlushD, fd);
        chk("FlushE", FlushE, fe);
`ifdef HAZARD_PERF_CNT_EN
        chk("StallCount", StallCount, m_cnt);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
        end else if (o_sf && m_cnt < CMAX) begin
            m_cnt++;
        end
        m_busy = n_busy; m_ldrem = n_ldrem; m_hold_a = n_hold_a; m_hold_b = n_hold_b;
        @(negedge clk);
    endtask

    initial begin
        m_busy = 0; m_ldrem = 0; m_hold_a = '0; m_hold_b = '0; m_cnt = 0;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);

        // Reset state, even with a hazard presented on the inputs.
        LoadE = 1; RdE = 7; Rs1D = 7;
        eval();
        chk("rst_StallF", StallF, 1'b0);
        chk("rst_FlushE", FlushE, 1'b0);
        tick();
        clear_inputs();
        rst = 1'b0;

        // Forwarding priorities.
        RD1E = 5; ResultW = 10; ALUResultM = 15; Rs1E = 3;
        RdM = 3; RegWriteM = 1;
        eval(); chk("fwd_m_code", ForwardAE, 2'b10); chk("fwd_m_val", SrcAE, 15); tick();
        RdM = 4; RdW = 3; RegWriteW = 1;
        eval(); chk("fwd_w_code", ForwardAE, 2'b01); chk("fwd_w_val", SrcAE, 10); tick();
        RdM = 3;
        eval(); chk("fwd_both_code", ForwardAE, 2'b10); chk("fwd_both_val", SrcAE, 15); tick();
        RdM = 0; Rs1E = 0; RdW = 0;
        eval(); chk("fwd_x0_code", ForwardAE, 2'b00); chk("fwd_x0_val", SrcAE, 5); tick();
        clear_inputs();

        // Load-use stall lasting LSC cycles.
        LoadE = 1; RdE = 7; Rs2D = 7;
        eval(); chk("ld_c0_StallF", StallF, 1'b1); chk("ld_c0_FlushE", FlushE, 1'b1); tick();
        LoadE = 0;
        eval(); chk("ld_c1_StallD", StallD, 1'b1); tick();
        eval(); chk("ld_c2_StallF", StallF, 1'b0); tick();

        // Branch beats load-use.
        LoadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        eval(); chk("br_FlushD", FlushD, 1'b1); chk("br_FlushE", FlushE, 1'b1);
        chk("br_StallF", StallF, 1'b0); tick();
        clear_inputs();
        eval(); chk("br_after_StallF", StallF, 1'b0); tick();

        // Multi-cycle op with held W-forwarded operand.
        Rs1E = 3; RdW = 3; RegWriteW = 1; ResultW = 10; RD1E = 5;
        MultiStartE = 1;
        eval(); chk("mc_issue_SrcAE", SrcAE, 10); chk("mc_issue_StallE", StallE, 1'b0); tick();
        for (int k = 1; k <= 4; k++) begin
            ResultW = 99; MultiStartE = 0; PCSrcE = k[0]; MultiDoneE = (k == 4);
            eval(); chk("mc_hold_SrcAE", SrcAE, 10); chk("mc_StallE", StallE, 1'b1);
            chk("mc_FlushD", FlushD, 1'b0); tick();
        end
        MultiDoneE = 0; PCSrcE = 0;
        eval(); chk("mc_exit_StallE", StallE, 1'b0); chk("mc_exit_SrcAE", SrcAE, 99); tick();

        // Asynchronous reset in the middle of MCWAIT.
        MultiStartE = 1; ResultW = 42;
        eval(); tick();
        MultiStartE = 0; ResultW = 43;
        eval(); chk("mcr_StallE", StallE, 1'b1); chk("mcr_SrcAE", SrcAE, 42); tick();
        #2 rst = 1'b1;
        #1;
        chk("mcr_async_StallE", StallE, 1'b0);
        chk("mcr_async_StallF", StallF, 1'b0);
        chk("mcr_async_SrcAE", SrcAE, 43);
        @(negedge clk);
        eval(); tick();
        rst = 1'b0;
        clear_inputs();

`ifdef HAZARD_PERF_CNT_EN
        // Ten stall cycles saturate a 3-bit counter.
        MultiStartE = 1;
        eval(); tick();
        MultiStartE = 0;
        for (int k = 0; k < 10; k++) begin
            eval(); tick();
        end
        MultiDoneE = 1;
        eval(); chk("perf_sat", StallCount, CMAX); tick();
        clear_inputs();
`endif

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 99) == 0);
            Rs1D        = RAW'($urandom_range(0, 3));
            Rs2D        = RAW'($urandom_range(0, 3));
            Rs1E        = RAW'($urandom_range(0, 3));
            Rs2E        = RAW'($urandom_range(0, 3));
            RdE         = RAW'($urandom_range(0, 3));
            RdM         = RAW'($urandom_range(0, 3));
            RdW         = RAW'($urandom_range(0, 3));
            RegWriteM   = $urandom_range(0, 1) == 1;
            RegWriteW   = $urandom_range(0, 1) == 1;
            LoadE       = $urandom_range(0, 3) == 0;
            PCSrcE      = $urandom_range(0, 7) == 0;
            MultiStartE = $urandom_range(0, 5) == 0;
            MultiDoneE  = $urandom_range(0, 2) == 0;
            RD1E        = $urandom;
            RD2E        = $urandom;
            ALUResultM  = $urandom;
            ResultW     = $urandom;
            eval();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
